// File: rtl/ozgun_ram_reader.sv
// Streams a contiguous block-RAM address range onto a valid/ready output with a last-word marker.
// Read-only: owns the RAM address bus while busy, never writes.
module ozgun_ram_reader #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  load_c;

    // Output register may be refilled when empty or drained this cycle
    assign load_c = !out_valid || out_ready;
    assign busy   = (state != IDLE);
    assign mem_we = 1'b0;

    // mem_addr doubles as the read pointer; it wraps modulo the address space.
    // A zero-length transfer spends one silent cycle in DONE before pulsing done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_addr  <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (length != '0) begin
                            mem_addr  <= base_addr;
                            remaining <= length;
                            state     <= STREAM;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                STREAM: begin
                    if (load_c) begin
                        out_data  <= mem_rdata;
                        out_valid <= 1'b1;
                        out_last  <= (remaining == (ADDR_WIDTH+1)'(1));
                        mem_addr  <= mem_addr + ADDR_WIDTH'(1);
                        remaining <= remaining - (ADDR_WIDTH+1)'(1);
                        if (remaining == (ADDR_WIDTH+1)'(1)) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (done) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ozgun_ram_reader.sv
// Scoreboard bench for ozgun_ram_reader: directed transfers push expected words,
// an independent monitor pops and compares on every output handshake.
module tb_ozgun_ram_reader;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 128;
    localparam int unsigned DEPTH = 64;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    ozgun_ram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word i encodes its own address in both halves
    function automatic logic [DW-1:0] word_of(input int a);
        return {64'(a) ^ 64'hC0DE_0000_0000_0000, 64'(a)};
    endfunction

    logic [DW-1:0] mem [DEPTH];
    initial for (int i = 0; i < int'(DEPTH); i++) mem[i] = word_of(i);
    assign mem_rdata = mem[mem_addr];

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   done_cnt;
    int   hs_cnt;
    logic [7:0] rdy_pat;
    logic [2:0] rdy_idx;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Consumer ready pattern, cycled one bit per clock
    initial begin
        out_ready = 1'b0;
        rdy_idx   = '0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_pat[rdy_idx];
            rdy_idx   = rdy_idx + 3'd1;
        end
    end

    exp_t          e;
    logic          prev_stall;
    logic          prev_done;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    // Monitor: every handshake pops the scoreboard; stalls must hold the word
    initial begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end else begin
                chk("mem_we", DW'(mem_we), DW'(0));
                if (prev_stall) begin
                    chk("stall_valid", DW'(out_valid), DW'(1));
                    chk("stall_data", out_data, prev_data);
                    chk("stall_last", DW'(out_last), DW'(prev_last));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word actual=%0h required=none", out_data);
                    end else begin
                        e = sb.pop_front();
                        chk("word_data", out_data, e.data);
                        chk("word_last", DW'(out_last), DW'(e.last));
                    end
                    hs_cnt++;
                end
                if (done) begin
                    done_cnt++;
                    chk("done_sb_empty", DW'(sb.size()), DW'(0));
                    chk("done_no_valid", DW'(out_valid), DW'(0));
                    chk("done_one_cycle", DW'(prev_done), DW'(0));
                end
                prev_done  = done;
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    // Issue a transfer: start sampled at the next edge (T), returns just after T
    task automatic launch(input int b, input int len);
        for (int k = 0; k < len; k++) begin
            sb.push_back('{data: word_of((b + k) % int'(DEPTH)), last: (k == len - 1)});
        end
        start     = 1'b1;
        base_addr = AW'(b);
        length    = (AW+1)'(len);
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = AW'(33);
        length    = (AW+1)'(7);
        chk("busy_after_start", DW'(busy), DW'(1));
    endtask

    task automatic wait_done(input int limit);
        int n0;
        n0 = done_cnt;
        for (int i = 0; i < limit && done_cnt == n0; i++) @(posedge clk);
        #1;
        chk("done_seen", DW'(done_cnt - n0), DW'(1));
    endtask

    int n0;
    int d0;

    initial begin
        checks = 0; errors = 0; done_cnt = 0; hs_cnt = 0;
        rdy_pat = 8'hFF;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", DW'(out_valid), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_data", out_data, DW'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_addr", DW'(mem_addr), DW'(0));
        chk("idle_done", DW'(done), DW'(0));
        chk("idle_last", DW'(out_last), DW'(0));
        chk("idle_busy", DW'(busy), DW'(0));

        // Basic burst: first word after T+1, four words back to back
        n0 = hs_cnt;
        launch(5, 4);
        repeat (2) @(negedge clk);
        #1;
        chk("first_valid", DW'(out_valid), DW'(1));
        chk("first_data", out_data, word_of(5));
        repeat (3) @(negedge clk);
        #1;
        chk("burst_rate", DW'(hs_cnt - n0), DW'(4));
        chk("burst_last", DW'(out_last), DW'(1));
        wait_done(20);
        @(posedge clk);
        #1;
        chk("busy_after_done", DW'(busy), DW'(0));

        // Backpressure
        rdy_pat = 8'h69;
        n0 = hs_cnt;
        launch(5, 4);
        wait_done(60);
        chk("bp_handshakes", DW'(hs_cnt - n0), DW'(4));

        // Ignored start mid-transfer
        launch(20, 6);
        repeat (3) @(negedge clk);
        start = 1'b1; base_addr = AW'(40); length = (AW+1)'(3);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(80);
        rdy_pat = 8'hFF;
        repeat (4) @(posedge clk);
        #1;
        chk("no_restart", DW'(busy), DW'(0));

        // Zero length
        d0 = done_cnt;
        launch(12, 0);
        @(negedge clk);
        #1;
        chk("zl_done_early", DW'(done), DW'(0));
        @(negedge clk);
        #1;
        chk("zl_done", DW'(done), DW'(1));
        chk("zl_busy_during", DW'(busy), DW'(1));
        @(negedge clk);
        #1;
        chk("zl_done_clear", DW'(done), DW'(0));
        chk("zl_busy_clear", DW'(busy), DW'(0));
        chk("zl_valid", DW'(out_valid), DW'(0));
        chk("zl_pulses", DW'(done_cnt - d0), DW'(1));

        // Full range with wrap, last on word 9
        launch(10, 64);
        wait_done(200);

        // Back-to-back, second transfer wraps 62,63,0,1
        launch(50, 3);
        wait_done(30);
        launch(62, 4);
        wait_done(30);

        // Reset mid-stream after three words
        n0 = hs_cnt;
        launch(30, 8);
        for (int i = 0; i < 40 && hs_cnt - n0 < 3; i++) @(posedge clk);
        chk("pre_reset_words", DW'(hs_cnt - n0 >= 3), DW'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        d0 = done_cnt;
        #1;
        chk("mid_rst_valid", DW'(out_valid), DW'(0));
        chk("mid_rst_busy", DW'(busy), DW'(0));
        chk("mid_rst_addr", DW'(mem_addr), DW'(0));
        chk("mid_rst_data", out_data, DW'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_rst_no_done", DW'(done_cnt - d0), DW'(0));
        chk("mid_rst_idle", DW'(busy), DW'(0));

        chk("sb_drained", DW'(sb.size()), DW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/ozgun_ram_reader.md
# ozgun_ram_reader

Read-side streaming controller for the single-port block RAM. On a start command it walks a contiguous address range, fetches one DATA_WIDTH word per address through the RAM's combinational read path, and presents the words on a valid/ready output stream with a last-word marker. It sits between the block RAM and any downstream consumer (DMA/output logic) and owns the RAM address bus while busy; it never writes.

## Interface
- ADDR_WIDTH, 6, RAM address width; address space is 2^ADDR_WIDTH words
- DATA_WIDTH, 128, RAM word width

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a transfer; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first word address; captured with start
- length  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; captured with start
- busy  out  1  high from the cycle after an accepted start until the done pulse, inclusive
- done  out  1  one-cycle pulse when the transfer is complete
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_we  out  1  RAM write enable; constant 0
- mem_rdata  in  DATA_WIDTH  RAM read data; combinational from mem_addr
- out_data  out  DATA_WIDTH  stream data
- out_valid  out  1  stream data valid
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready
- out_last  out  1  qualifies the final word of the transfer

## Operation
- State machine: IDLE, STREAM, FLUSH, DONE.
- IDLE: start=1 with length>0 captures ptr<=base_addr, remaining<=length, goes to STREAM. start=1 with length=0 goes directly to DONE; no words are emitted. start=0 stays in IDLE.
- STREAM: load condition is (!out_valid || out_ready). On load:
  - out_data<=mem_rdata, out_valid<=1, out_last<=(remaining==1)
  - ptr<=ptr+1, remaining<=remaining-1
  - If remaining==1, go to FLUSH.
  - Without a load, all output registers hold.
- FLUSH: the last word is held. On out_ready it is consumed: out_valid<=0, out_last<=0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- mem_addr = ptr, registered. In IDLE it holds its last value; after reset it is 0.
- Address arithmetic is modulo 2^ADDR_WIDTH. base_addr=62 with length=4 (ADDR_WIDTH=6) reads 62, 63, 0, 1.
- length=2^ADDR_WIDTH reads every word exactly once, starting at base_addr.
- start in any state other than IDLE is ignored, including base_addr and length.
- Stream rules:
  - out_data and out_last are stable while out_valid=1 && out_ready=0.
  - out_valid never drops without a handshake.
  - out_ready is ignored while out_valid=0.
- busy = (state != IDLE).
- Reset (any time, including mid-transfer) forces IDLE, ptr=0, remaining=0, mem_addr=0, mem_we=0, out_valid=0, out_last=0, out_data=0, done=0, busy=0. An interrupted transfer is abandoned; no done pulse is issued.

## Timing
- All outputs are registered except mem_we (tied 0) and busy, which is decoded from the state register.
- Start accepted at edge T (length>0): busy=1 from T. Word base_addr is valid after edge T+1.
- With out_ready held high: one word per cycle, and the last word is valid after edge T+length.
- Last handshake at edge H: done=1 during the cycle after H, busy falls after edge H+1. The earliest next accepted start is edge H+2.
- length=0: start at edge T gives done=1 after edge T+1 and busy=0 after edge T+2.
- Backpressure costs no bubbles: a word is replaced in the same cycle it is consumed.

## Test plan
- Reset values: hold rst_n=0, then release -> all outputs 0, state IDLE. Assert rst_n low mid-STREAM (length=8, after 3 words) -> next cycle out_valid=0, busy=0, and no done pulse.
- Basic burst: RAM preloaded mem[i]=i, base_addr=5, length=4, out_ready=1 -> words 5, 6, 7, 8 on consecutive cycles, out_last only on 8, then one done pulse.
- Backpressure: same burst, out_ready toggled 1,0,0,1,0,1,... -> each word held stable while stalled, no word dropped or duplicated, exactly 4 handshakes.
- Wrap and full range: base_addr=62, length=4 -> words 62, 63, 0, 1. base_addr=10, length=64 -> 64 words, 10..63 then 0..9, and out_last on word 9.
- Zero length and ignored start: length=0 -> done pulse with out_valid never asserted. Pulse start with new base_addr/length mid-transfer -> the ongoing stream is unaffected.
- Back-to-back: issue a second start at the earliest IDLE cycle after done -> the second transfer streams correctly and mem_we stays 0 throughout.
